// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream receive endpoint.
//   axis_beat_t : one stored stream beat (data, strobes, keeps, user, last)
//   rx_state_e  : ingress packet-framing FSM states
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_STRB_W = 4;
  localparam int unsigned AXIS_USER_W = 2;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   tlast;
  } axis_beat_t;

  localparam int unsigned AXIS_BEAT_W = $bits(axis_beat_t);

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_PKT  = 1'b1
  } rx_state_e;

endpackage : axis_pkg

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO, no packet awareness.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   wr_vld_i / wr_data_i  : write request and payload
//   wr_rdy_c_o            : space available (comb from registered count)
//   rd_vld_c_o            : head entry valid (comb from registered count)
//   rd_data_c_o           : head entry, zero when empty
//   rd_rdy_i              : consumer pops the head entry
//   count_o               : current occupancy
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic                       wr_rdy_c_o,
  output logic                       rd_vld_c_o,
  output logic [WIDTH-1:0]           rd_data_c_o,
  input  logic                       rd_rdy_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign wr_rdy_c_o  = (count_q < CW'(DEPTH));
  assign rd_vld_c_o  = (count_q != '0);
  assign rd_data_c_o = rd_vld_c_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  assign push = wr_vld_i & wr_rdy_c_o;
  assign pop  = rd_vld_c_o & rd_rdy_i;

  // Pointers wrap naturally; count tracks push/pop balance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule : axis_sync_fifo

// File: rtl/axis_slave.sv
// AXI-Stream receive endpoint: buffers upstream beats in a FWFT FIFO and
// presents them to the backend with packet framing and status.
// Ports:
//   axi_aclk, axi_aresetn          : clock, async active-low reset
//   axis_t*                        : upstream AXI-Stream slave interface
//   bk_valid/bk_ready, bk_data...  : backend head-of-FIFO beat handshake
//   bk_done, bk_len                : packet completion pulse and its length
//   bk_nordy                       : backend stall timeout flag
//   bk_err_len, bk_clr_err         : sticky over-length error and its clear
module axis_slave
  import axis_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [15:0] MAX_PKT_LEN    = 16'd256,
  parameter logic [7:0]  BK_RDY_TIMEOUT = 8'd5
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   axis_tvalid,
  input  logic [AXIS_DATA_W-1:0] axis_tdata,
  input  logic [AXIS_STRB_W-1:0] axis_tstrb,
  input  logic [AXIS_STRB_W-1:0] axis_tkeep,
  input  logic                   axis_tlast,
  input  logic [AXIS_USER_W-1:0] axis_tuser,
  output logic                   axis_tready,
  output logic                   bk_valid,
  output logic [AXIS_DATA_W-1:0] bk_data,
  output logic [AXIS_STRB_W-1:0] bk_tstrb,
  output logic [AXIS_STRB_W-1:0] bk_tkeep,
  output logic [AXIS_USER_W-1:0] bk_user,
  output logic                   bk_last,
  input  logic                   bk_ready,
  output logic                   bk_done,
  output logic [15:0]            bk_len,
  output logic                   bk_nordy,
  output logic                   bk_err_len,
  input  logic                   bk_clr_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_e        state_q, state_d;
  logic [15:0]      rx_cnt_q, rx_cnt_d;
  logic [15:0]      tx_cnt_q, tx_cnt_d;
  logic [7:0]       stall_q, stall_d;
  logic             err_q, err_d;
  logic [15:0]      beat_num_c;
  logic             forced_end_c;
  logic             push, pop;
  logic             fifo_wr_rdy, fifo_rd_vld;
  logic [CNT_W-1:0] fifo_count;
  axis_beat_t       wr_beat, rd_beat;

  assign push = axis_tvalid & axis_tready;
  assign pop  = bk_valid & bk_ready;

  assign wr_beat = '{tdata: axis_tdata, tstrb: axis_tstrb, tkeep: axis_tkeep,
                     tuser: axis_tuser, tlast: axis_tlast | forced_end_c};

  axis_sync_fifo #(
    .WIDTH (AXIS_BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .wr_vld_i    (axis_tvalid),
    .wr_data_i   (wr_beat),
    .wr_rdy_c_o  (fifo_wr_rdy),
    .rd_vld_c_o  (fifo_rd_vld),
    .rd_data_c_o (rd_beat),
    .rd_rdy_i    (bk_ready),
    .count_o     (fifo_count)
  );

  assign axis_tready = fifo_wr_rdy;
  assign bk_valid    = fifo_rd_vld;
  assign bk_data     = rd_beat.tdata;
  assign bk_tstrb    = rd_beat.tstrb;
  assign bk_tkeep    = rd_beat.tkeep;
  assign bk_user     = rd_beat.tuser;
  assign bk_last     = rd_beat.tlast;
  assign bk_nordy    = (stall_q >= BK_RDY_TIMEOUT);
  assign bk_err_len  = err_q;

  // Ingress framing FSM; a packet reaching MAX_PKT_LEN without tlast is cut.
  always_comb begin
    state_d      = state_q;
    rx_cnt_d     = rx_cnt_q;
    forced_end_c = 1'b0;
    beat_num_c   = 16'd1;
    case (state_q)
      RX_IDLE: beat_num_c = 16'd1;
      RX_PKT:  beat_num_c = rx_cnt_q + 16'd1;
      default: beat_num_c = 16'd1;
    endcase
    if (push) begin
      forced_end_c = ~axis_tlast & (beat_num_c == MAX_PKT_LEN);
      if (axis_tlast | forced_end_c) begin
        state_d  = RX_IDLE;
        rx_cnt_d = '0;
      end else begin
        state_d  = RX_PKT;
        rx_cnt_d = beat_num_c;
      end
    end
  end

  // Egress length tracking, stall timer and sticky error (set wins).
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    bk_done  = 1'b0;
    bk_len   = '0;
    stall_d  = stall_q;
    err_d    = err_q;
    if (pop) begin
      if (rd_beat.tlast) begin
        bk_done  = 1'b1;
        bk_len   = tx_cnt_q + 16'd1;
        tx_cnt_d = '0;
      end else begin
        tx_cnt_d = tx_cnt_q + 16'd1;
      end
    end
    if (pop || fifo_count == '0) begin
      stall_d = '0;
    end else if (stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
    if (bk_clr_err)   err_d = 1'b0;
    if (forced_end_c) err_d = 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

endmodule : axis_slave

// File: doc/axis_slave.md
Name: axis_slave

Overview:
- Receive-side AXI-Stream endpoint; mirror of the transmit-side master.
- Accepts beats from an upstream AXI-Stream master into an internal FWFT FIFO and presents them to backend logic over a valid/ready interface.
- Tracks packet framing via tlast.
- Reports per-packet beat count, packet-done pulse, backend-stall timeout and over-length error.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
MAX_PKT_LEN, 16'd256, beats allowed per packet before length error (1..65535)
BK_RDY_TIMEOUT, 8'd5, consecutive backend-stall cycles before bk_nordy asserts

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  async active-low reset
axis_tvalid  in  1  upstream beat valid
axis_tdata  in  32  beat data
axis_tstrb  in  4  byte strobes
axis_tkeep  in  4  byte keeps
axis_tlast  in  1  last beat of packet
axis_tuser  in  2  user sideband
axis_tready  out  1  slave ready
bk_valid  out  1  beat available to backend
bk_data  out  32  head beat data
bk_tstrb  out  4  head beat strobes
bk_tkeep  out  4  head beat keeps
bk_user  out  2  head beat user
bk_last  out  1  head beat is packet end (incl. forced end)
bk_ready  in  1  backend consumes head beat
bk_done  out  1  one-cycle pulse when a last beat is consumed
bk_len  out  16  beat count of the packet just completed; valid while bk_done=1
bk_nordy  out  1  backend stall timeout flag
bk_err_len  out  1  sticky over-length error; cleared by bk_clr_err
bk_clr_err  in  1  clears bk_err_len

Behaviour:
- Clock and reset: one clock axi_aclk; reset axi_aresetn is asynchronous, active-low.
- Reset values: all outputs 0 except axis_tready=1 (FIFO empty); pointers, counters and FSM cleared.
- Reset mid-packet discards FIFO contents and partial packet state.
- Ingress accept: axis_tvalid & axis_tready.
  - axis_tready = (fifo_count < FIFO_DEPTH); combinational from registered count.
  - No dependency on axis_tvalid.
- Egress pop: bk_valid & bk_ready.
  - bk_valid = (fifo_count != 0).
  - FWFT: the head beat and its sideband are driven from the read-pointer entry in the same cycle.
  - Outputs read 0 when empty.
- Latency: a beat accepted at edge N is visible on bk_* in cycle N+1.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - When full, tready=0, so a pop that cycle does not allow a same-cycle push.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_count is one bit wider.
- Ingress FSM:
  - RX_IDLE -> RX_PKT on an accepted beat with tlast=0.
  - RX_IDLE stays on an accepted beat with tlast=1 (single-beat packet).
  - RX_PKT -> RX_IDLE on an accepted beat with tlast=1, or when rx_cnt reaches MAX_PKT_LEN.
- rx_cnt (16b):
  - Counts accepted beats of the current packet; reset to 0 on return to RX_IDLE.
  - When an accepted beat makes rx_cnt==MAX_PKT_LEN without tlast: that beat is stored with last=1, bk_err_len sets, FSM returns to RX_IDLE.
  - Following beats start a new packet.
- Stored last bit = axis_tlast | forced_end.
- Egress counter tx_cnt (16b) increments per pop.
  - On popping a beat with last=1: bk_done=1 for that cycle, bk_len = tx_cnt+1, tx_cnt cleared.
- bk_err_len:
  - Sets on over-length.
  - Clears on bk_clr_err.
  - Set has priority over clear in the same cycle.
- bk_nordy:
  - stall counter (8b, saturating) increments while bk_valid=1 and bk_ready=0.
  - Clears on any pop or when empty.
  - bk_nordy = (stall >= BK_RDY_TIMEOUT).
- No tready deassertion occurs mid-packet except when the FIFO is full.

Decomposition:
- Package axis_pkg:
  - AXIS_DATA_W=32, AXIS_STRB_W=4, AXIS_USER_W=2.
  - packed struct axis_beat_t {tdata, tstrb, tkeep, tuser, tlast}, 43 bits.
  - rx_state_e {RX_IDLE, RX_PKT}.
- Sub-module axis_sync_fifo #(WIDTH, DEPTH):
  - Plain FWFT FIFO with wr_vld/wr_rdy/rd_vld/rd_rdy and count.
  - No packet awareness.
- Top level holds the FSM, counters and flags.

Test Plan:
1. 4-beat packet (tdata 0x11..0x44, tlast on 4th), bk_ready=1 -> bk_data 0x11..0x44 one cycle after each accept; bk_done on 0x44 pop; bk_len=4; tready always 1.
2. bk_ready=0, send 10 beats -> tready drops after 8 accepts. bk_nordy asserts 5 cycles after first bk_valid. Raise bk_ready -> all 10 beats out in order; tready returns one cycle after first pop.
3. Single-beat packet 0xDEADBEEF with tlast=1, tuser=2'b10, tkeep=4'hF -> bk_last=1, bk_user=2'b10, bk_done with bk_len=1; FSM stays RX_IDLE.
4. MAX_PKT_LEN=4, send 6 beats with no tlast -> 4th beat has bk_last=1 and bk_err_len=1; bk_len=4; beats 5-6 form the next packet. bk_clr_err clears the flag.
5. Continuous streaming, tvalid and bk_ready both held at 1 for 100 beats across pointer wrap -> no bubbles after first beat; data order intact; count stays at 1.
6. Reset asserted mid-packet with 3 beats buffered -> bk_valid=0, tready=1, bk_err_len=0 immediately. Next packet after reset has bk_len counted from 1.
